// File: rtl/rvpc_clint_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvpc_clint_pkg
// Brief    : CLINT register offsets, reset values and address decode helper.
// Revision : 1.0
// ============================================================================
package rvpc_clint_pkg;

    localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI      = 16'hBFFC;
    localparam logic [63:0] MTIMECMP_RST        = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ACC_NONE     = 2'd0,
        ACC_MSIP     = 2'd1,
        ACC_MTIMECMP = 2'd2,
        ACC_MTIME    = 2'd3
    } clint_region_e;

    typedef struct packed {
        clint_region_e region;
        logic [3:0]    hart;
        logic          hi;
    } clint_decode_t;

    // With at most 16 harts the msip window is 0x00-0x3F and mtimecmp is 0x4000-0x407F.
    function automatic clint_decode_t clint_decode(input logic [15:0] addr, input int n_harts);
        clint_decode_t d;
        d.region = ACC_NONE;
        d.hart   = 4'd0;
        d.hi     = 1'b0;
        if (addr[1:0] == 2'b00) begin
            if (addr[15:6] == CLINT_MSIP_BASE[15:6] && int'({28'd0, addr[5:2]}) < n_harts) begin
                d.region = ACC_MSIP;
                d.hart   = addr[5:2];
            end else if (addr[15:7] == CLINT_MTIMECMP_BASE[15:7] &&
                         int'({28'd0, addr[6:3]}) < n_harts) begin
                d.region = ACC_MTIMECMP;
                d.hart   = addr[6:3];
                d.hi     = addr[2];
            end else if (addr == CLINT_MTIME_LO) begin
                d.region = ACC_MTIME;
            end else if (addr == CLINT_MTIME_HI) begin
                d.region = ACC_MTIME;
                d.hi     = 1'b1;
            end
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvpc_clint_if.sv
`default_nettype none
// ============================================================================
// Module   : rvpc_clint_if
// Brief    : Single-cycle strobe bus between the CPU data path and the CLINT.
// Revision : 1.0
// ============================================================================
interface rvpc_clint_if;
    logic        w_en;
    logic        w_we;
    logic [15:0] w_addr;
    logic [31:0] w_wdata;
    logic [31:0] r_rdata;
    logic        r_rvalid;

    modport master (output w_en, w_we, w_addr, w_wdata, input r_rdata, r_rvalid);
    modport slave  (input w_en, w_we, w_addr, w_wdata, output r_rdata, r_rvalid);
endinterface
`default_nettype wire

// File: rtl/rvpc_mtime_counter.sv
`default_nettype none
// ============================================================================
// Module   : rvpc_mtime_counter
// Brief    : Prescaled 64-bit mtime counter with half-word software writes.
// Revision : 1.0
// ============================================================================
module rvpc_mtime_counter #(
    parameter int TICK_DIV = 100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] mtime
);

    localparam int            c_presc_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_DIV - 1);

    logic [c_presc_w-1:0] r_presc;
    logic                 w_tick;

    assign w_tick = enable && (r_presc == c_presc_max);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_presc <= '0;
            mtime   <= '0;
        end else begin
            if (enable) begin
                r_presc <= w_tick ? '0 : r_presc + c_presc_w'(1);
            end
            // A software write swallows a coincident tick; the prescaler still wraps.
            if (we_lo) begin
                mtime <= {mtime[63:32], wdata};
            end else if (we_hi) begin
                mtime <= {wdata, mtime[31:0]};
            end else if (w_tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rvpc_clint.sv
`default_nettype none
// ============================================================================
// Module   : rvpc_clint
// Brief    : Core-local interruptor: mtime, per-hart mtimecmp/msip, mtip/msip.
// Revision : 1.0
// ============================================================================
module rvpc_clint
    import rvpc_clint_pkg::*;
#(
    parameter int N_HARTS  = 1,
    parameter int TICK_DIV = 100
) (
    input  logic               CLK,
    input  logic               RST,
    rvpc_clint_if.slave        bus,
    input  logic               w_mtime_en,
    output logic [N_HARTS-1:0] w_mtip,
    output logic [N_HARTS-1:0] w_msip,
    output logic [63:0]        w_mtime
);

    clint_decode_t w_dec;
    logic          w_wr;
    logic          w_rd;
    logic [31:0]   w_rdata_mux;
    logic [63:0]   r_mtimecmp [N_HARTS];

    assign w_dec = clint_decode(bus.w_addr, N_HARTS);
    assign w_wr  = bus.w_en &  bus.w_we;
    assign w_rd  = bus.w_en & ~bus.w_we;

    rvpc_mtime_counter #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime (
        .CLK    (CLK),
        .RST    (RST),
        .enable (w_mtime_en),
        .we_lo  (w_wr && w_dec.region == ACC_MTIME && !w_dec.hi),
        .we_hi  (w_wr && w_dec.region == ACC_MTIME &&  w_dec.hi),
        .wdata  (bus.w_wdata),
        .mtime  (w_mtime)
    );

    // Compare uses the registered operands, so mtip trails any operand change by one edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int h = 0; h < N_HARTS; h++) begin
                r_mtimecmp[h] <= MTIMECMP_RST;
            end
            w_msip <= '0;
            w_mtip <= '0;
        end else begin
            for (int h = 0; h < N_HARTS; h++) begin
                if (w_wr && w_dec.region == ACC_MTIMECMP && w_dec.hart == 4'(h)) begin
                    if (w_dec.hi) begin
                        r_mtimecmp[h][63:32] <= bus.w_wdata;
                    end else begin
                        r_mtimecmp[h][31:0]  <= bus.w_wdata;
                    end
                end
                if (w_wr && w_dec.region == ACC_MSIP && w_dec.hart == 4'(h)) begin
                    w_msip[h] <= bus.w_wdata[0];
                end
                w_mtip[h] <= (w_mtime >= r_mtimecmp[h]);
            end
        end
    end

    always_comb begin
        w_rdata_mux = '0;
        case (w_dec.region)
            ACC_MSIP: begin
                for (int h = 0; h < N_HARTS; h++) begin
                    if (w_dec.hart == 4'(h)) begin
                        w_rdata_mux = {31'd0, w_msip[h]};
                    end
                end
            end
            ACC_MTIMECMP: begin
                for (int h = 0; h < N_HARTS; h++) begin
                    if (w_dec.hart == 4'(h)) begin
                        w_rdata_mux = w_dec.hi ? r_mtimecmp[h][63:32] : r_mtimecmp[h][31:0];
                    end
                end
            end
            ACC_MTIME: w_rdata_mux = w_dec.hi ? w_mtime[63:32] : w_mtime[31:0];
            default:   w_rdata_mux = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.r_rdata  <= '0;
            bus.r_rvalid <= 1'b0;
        end else begin
            bus.r_rvalid <= w_rd;
            if (w_rd) begin
                bus.r_rdata <= w_rdata_mux;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvpc_clint.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvpc_clint
// Brief    : Self-checking bench for rvpc_clint against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_rvpc_clint;

    localparam int NH = 2;
    localparam int TD = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          mtime_en;
    logic [NH-1:0] mtip;
    logic [NH-1:0] msip;
    logic [63:0]   mtime;

    rvpc_clint_if bus ();

    rvpc_clint #(
        .N_HARTS  (NH),
        .TICK_DIV (TD)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus.slave),
        .w_mtime_en (mtime_en),
        .w_mtip     (mtip),
        .w_msip     (msip),
        .w_mtime    (mtime)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Reference state
    logic [63:0]   m_mtime;
    int unsigned   m_en_cnt;
    logic [63:0]   m_cmp [NH];
    logic [NH-1:0] m_msip;
    logic [NH-1:0] m_mtip;
    logic [31:0]   m_rdata;
    logic          m_rvalid;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [31:0] data;   // write data, or expected read data
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int a);
        if (a % 4 != 0) return 32'd0;
        if (a < 4 * NH) return {31'd0, m_msip[a / 4]};
        if (a >= 'h4000 && a < 'h4000 + 8 * NH)
            return (a % 8 == 4) ? m_cmp[(a - 'h4000) / 8][63:32] : m_cmp[(a - 'h4000) / 8][31:0];
        if (a == 'hBFF8) return m_mtime[31:0];
        if (a == 'hBFFC) return m_mtime[63:32];
        return 32'd0;
    endfunction

    task automatic model_step();
        int  a;
        bit  tick;
        bit  written;
        if (RST) begin
            m_mtime  = '0;
            m_en_cnt = 0;
            for (int h = 0; h < NH; h++) m_cmp[h] = '1;
            m_msip   = '0;
            m_mtip   = '0;
            m_rdata  = '0;
            m_rvalid = 1'b0;
        end else begin
            for (int h = 0; h < NH; h++) m_mtip[h] = (m_mtime >= m_cmp[h]);
            a        = int'(bus.w_addr);
            m_rvalid = bus.w_en && !bus.w_we;
            if (m_rvalid) m_rdata = model_read(a);
            tick = mtime_en && (m_en_cnt % TD == TD - 1);
            if (mtime_en) m_en_cnt++;
            written = 0;
            if (bus.w_en && bus.w_we && a % 4 == 0) begin
                if (a < 4 * NH) m_msip[a / 4] = bus.w_wdata[0];
                else if (a >= 'h4000 && a < 'h4000 + 8 * NH) begin
                    if (a % 8 == 4) m_cmp[(a - 'h4000) / 8][63:32] = bus.w_wdata;
                    else            m_cmp[(a - 'h4000) / 8][31:0]  = bus.w_wdata;
                end else if (a == 'hBFF8) begin
                    m_mtime[31:0] = bus.w_wdata;
                    written = 1;
                end else if (a == 'hBFFC) begin
                    m_mtime[63:32] = bus.w_wdata;
                    written = 1;
                end
            end
            if (tick && !written) m_mtime = m_mtime + 64'd1;
        end
    endtask

    // One clock: advance the model at the edge, compare everything just after it.
    task automatic cyc();
        @(posedge CLK);
        model_step();
        #1;
        chk("rvalid", {63'd0, bus.r_rvalid}, {63'd0, m_rvalid});
        chk("rdata",  {32'd0, bus.r_rdata},  {32'd0, m_rdata});
        chk("mtime",  mtime, m_mtime);
        chk("mtip",   {62'd0, mtip}, {62'd0, m_mtip});
        chk("msip",   {62'd0, msip}, {62'd0, m_msip});
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] data);
        bus.w_en = 1'b1; bus.w_we = 1'b1; bus.w_addr = addr; bus.w_wdata = data;
        cyc();
        bus.w_en = 1'b0; bus.w_we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input logic [31:0] exp, input string name);
        bus.w_en = 1'b1; bus.w_we = 1'b0; bus.w_addr = addr;
        cyc();
        bus.w_en = 1'b0;
        chk({name, "_rvalid"}, {63'd0, bus.r_rvalid}, 64'd1);
        chk(name, {32'd0, bus.r_rdata}, {32'd0, exp});
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] pick [13];
        bit          found;

        RST = 1'b1; mtime_en = 1'b0;
        bus.w_en = 1'b0; bus.w_we = 1'b0; bus.w_addr = '0; bus.w_wdata = '0;

        tbl[0]  = '{1'b1, 16'h0004, 32'hFFFF_FFFF};
        tbl[1]  = '{1'b0, 16'h0004, 32'h0000_0001};
        tbl[2]  = '{1'b0, 16'h0000, 32'h0000_0000};
        tbl[3]  = '{1'b1, 16'h0008, 32'h0000_0001};
        tbl[4]  = '{1'b0, 16'h0008, 32'h0000_0000};
        tbl[5]  = '{1'b1, 16'h0002, 32'h0000_0001};
        tbl[6]  = '{1'b0, 16'h0000, 32'h0000_0000};
        tbl[7]  = '{1'b0, 16'h4000, 32'hFFFF_FFFF};
        tbl[8]  = '{1'b1, 16'h4008, 32'h1234_5678};
        tbl[9]  = '{1'b0, 16'h4008, 32'h1234_5678};
        tbl[10] = '{1'b0, 16'h400C, 32'hFFFF_FFFF};
        tbl[11] = '{1'b1, 16'h4010, 32'h0000_0005};
        tbl[12] = '{1'b0, 16'h4010, 32'h0000_0000};
        tbl[13] = '{1'b0, 16'h1000, 32'h0000_0000};
        tbl[14] = '{1'b1, 16'hBFFC, 32'h0000_000A};
        tbl[15] = '{1'b0, 16'hBFFC, 32'h0000_000A};
        tbl[16] = '{1'b0, 16'hBFF8, 32'h0000_0000};
        tbl[17] = '{1'b1, 16'hBFFA, 32'h0000_0077};
        tbl[18] = '{1'b0, 16'hBFF8, 32'h0000_0000};

        // Reset and idle
        cyc(); cyc();
        RST = 1'b0;
        repeat (5) cyc();
        chk("idle_mtime", mtime, 64'd0);
        chk("idle_mtip", {62'd0, mtip}, 64'd0);
        chk("idle_msip", {62'd0, msip}, 64'd0);
        rd(16'h4000, 32'hFFFF_FFFF, "rst_cmp_lo");
        cyc();
        chk("rvalid_pulse", {63'd0, bus.r_rvalid}, 64'd0);
        rd(16'h4004, 32'hFFFF_FFFF, "rst_cmp_hi");

        // Prescaled counting and hold
        do_reset();
        mtime_en = 1'b1;
        repeat (40) cyc();
        chk("count40", mtime, 64'd10);
        mtime_en = 1'b0;
        repeat (8) cyc();
        chk("hold8", mtime, 64'd10);

        // Timer interrupt edge timing
        do_reset();
        wr(16'h4000, 32'h20);
        wr(16'h4004, 32'h0);
        mtime_en = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc();
            if (mtime == 64'h20) found = 1;
        end
        chk("reach_20", mtime, 64'h20);
        chk("mtip_pre", {63'd0, mtip[0]}, 64'd0);
        cyc();
        chk("mtip_rise", {63'd0, mtip[0]}, 64'd1);
        chk("mtip1_low", {63'd0, mtip[1]}, 64'd0);
        mtime_en = 1'b0;
        wr(16'h4004, 32'h1);
        chk("mtip_hold", {63'd0, mtip[0]}, 64'd1);
        cyc();
        chk("mtip_fall", {63'd0, mtip[0]}, 64'd0);

        // Carry from lo into hi
        wr(16'hBFF8, 32'hFFFF_FFFF);
        wr(16'hBFFC, 32'h0);
        mtime_en = 1'b1;
        found = 0;
        for (int i = 0; i < 2 * TD && !found; i++) begin
            cyc();
            if (mtime == 64'h1_0000_0000) found = 1;
        end
        mtime_en = 1'b0;
        chk("carry", mtime, 64'h1_0000_0000);
        rd(16'hBFFC, 32'h1, "carry_hi");
        rd(16'hBFF8, 32'h0, "carry_lo");

        // Write coincident with a tick
        do_reset();
        mtime_en = 1'b1;
        repeat (3) cyc();
        wr(16'hBFF8, 32'h55);
        chk("wr_vs_tick", mtime, 64'h55);
        repeat (3) cyc();
        chk("post_wr_hold", mtime, 64'h55);
        cyc();
        chk("post_wr_tick", mtime, 64'h56);

        // Register map table
        do_reset();
        mtime_en = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].we) wr(tbl[i].addr, tbl[i].data);
            else           rd(tbl[i].addr, tbl[i].data, $sformatf("tbl%0d", i));
        end
        cyc();
        chk("tbl_msip", {62'd0, msip}, 64'd2);

        // Reset cancels an in-flight read
        bus.w_en = 1'b1; bus.w_we = 1'b0; bus.w_addr = 16'hBFF8;
        RST = 1'b1;
        cyc();
        RST = 1'b0; bus.w_en = 1'b0;
        chk("rst_cancel", {63'd0, bus.r_rvalid}, 64'd0);
        chk("rst_mtime", mtime, 64'd0);
        rd(16'h4008, 32'hFFFF_FFFF, "rst_cmp1_lo");
        rd(16'h400C, 32'hFFFF_FFFF, "rst_cmp1_hi");
        rd(16'h4004, 32'hFFFF_FFFF, "rst_cmp0_hi");

        // Randomised traffic against the model
        pick[0] = 16'h0000;  pick[1] = 16'h0004;  pick[2] = 16'h0008;  pick[3] = 16'h0002;
        pick[4] = 16'h4000;  pick[5] = 16'h4004;  pick[6] = 16'h4008;  pick[7] = 16'h400C;
        pick[8] = 16'h4010;  pick[9] = 16'hBFF8;  pick[10] = 16'hBFFC; pick[11] = 16'hBFFA;
        pick[12] = 16'h0000;
        for (int i = 0; i < 400; i++) begin
            RST         = ($urandom_range(63) == 0);
            mtime_en    = ($urandom_range(3) != 0);
            bus.w_en    = $urandom_range(1);
            bus.w_we    = $urandom_range(1);
            bus.w_addr  = ($urandom_range(9) == 0) ? 16'($urandom) : pick[$urandom_range(11)];
            bus.w_wdata = $urandom_range(1) ? $urandom : 32'($urandom_range(63));
            cyc();
        end
        RST = 1'b0; bus.w_en = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
